// File: rtl/sequenciador_indices.sv
// sequenciador_indices: requests random draws, retries rejected ones and emits the accepted 4x2-bit permutation one index per ack.
// Optional build macro SEQ_CHECK_EN: when defined, a ready draw is accepted only if its four slots are pairwise distinct.
module sequenciador_indices #(
  parameter int GEN_LAT        = 2,
  parameter int MAX_TENTATIVAS = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [7:0] perm,
  input  logic       perm_ready,
  output logic       prox_aleatorio,
  output logic [1:0] indice,
  output logic       indice_valido,
  input  logic       indice_ack,
  output logic       pronto,
  output logic       ocupado,
  output logic       erro_timeout,
  output logic [7:0] tentativas
);
  typedef enum logic [2:0] {IDLE, SORTEIA, ESPERA, AVALIA, EMITE, FIM} estado_t;
  localparam int CW = GEN_LAT > 1 ? $clog2(GEN_LAT) : 1;
  localparam logic [CW-1:0] ESPERA_INI = CW'(GEN_LAT - 1);
  localparam logic [7:0] MAX_T = 8'(MAX_TENTATIVAS);
  localparam logic [7:0] IDENTIDADE = 8'h1B;
  estado_t estado, prox_estado;
  logic [CW-1:0] espera_cnt;
  logic [7:0] perm_q;
  logic [1:0] slot;
  logic aceita, transfer, esgotou;
`ifdef SEQ_CHECK_EN
  function automatic logic is_perm(input logic [7:0] p);
    return p[7:6] != p[5:4] && p[7:6] != p[3:2] && p[7:6] != p[1:0] &&
           p[5:4] != p[3:2] && p[5:4] != p[1:0] && p[3:2] != p[1:0];
  endfunction
  assign aceita = perm_ready && is_perm(perm);
`else
  assign aceita = perm_ready;
`endif
  assign transfer = estado == EMITE && indice_ack;
  assign esgotou  = tentativas >= MAX_T;
  // state register; a low reset returns to IDLE from anywhere, abandoning any partial sequence
  always_ff @(posedge clock) begin
    if (!reset) estado <= IDLE;
    else estado <= prox_estado;
  end
  // next-state logic and outputs decoded from the registered state and latched permutation
  always_comb begin
    prox_estado    = estado;
    prox_aleatorio = estado == SORTEIA;
    indice_valido  = estado == EMITE;
    pronto         = estado == FIM;
    ocupado        = estado != IDLE;
    indice         = perm_q[{~slot, 1'b0} +: 2];
    unique case (estado)
      IDLE:    prox_estado = iniciar ? SORTEIA : IDLE;
      SORTEIA: prox_estado = ESPERA;
      ESPERA:  prox_estado = espera_cnt == '0 ? AVALIA : ESPERA;
      AVALIA:  prox_estado = (aceita || esgotou) ? EMITE : SORTEIA;
      EMITE:   prox_estado = (transfer && slot == 2'd3) ? FIM : EMITE;
      FIM:     prox_estado = IDLE;
      default: prox_estado = IDLE;
    endcase
  end
  // draw counter, generator wait timer, latched permutation, emit slot and sticky timeout flag
  always_ff @(posedge clock) begin
    if (!reset) begin
      tentativas   <= '0;
      erro_timeout <= 1'b0;
      perm_q       <= '0;
      slot         <= '0;
      espera_cnt   <= '0;
    end else begin
      unique case (estado)
        IDLE: if (iniciar) begin
          tentativas   <= '0;
          erro_timeout <= 1'b0;
        end
        SORTEIA: begin
          tentativas <= tentativas + 8'd1;
          espera_cnt <= ESPERA_INI;
        end
        ESPERA: if (espera_cnt != '0) espera_cnt <= espera_cnt - CW'(1);
        AVALIA: if (aceita) begin
          perm_q <= perm;
          slot   <= '0;
        end else if (esgotou) begin
          perm_q       <= IDENTIDADE;
          slot         <= '0;
          erro_timeout <= 1'b1;
        end
        EMITE: if (transfer) slot <= slot + 2'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sequenciador_indices.sv
// tb_sequenciador_indices: table-driven checks of draw/retry/fallback/emit behaviour plus reset and FIM corner cases.
module tb_sequenciador_indices;
  localparam int GEN_LAT = 2;
  localparam int MAXT    = 8;
  logic clock = 1'b0;
  logic reset, iniciar, perm_ready, indice_ack;
  logic [7:0] perm;
  logic prox_aleatorio, indice_valido, pronto, ocupado, erro_timeout;
  logic [1:0] indice;
  logic [7:0] tentativas;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         acc;
    logic [7:0] perm1;
    logic [7:0] permv;
    logic [7:0] exp_seq;
    int         exp_prox;
    int         exp_err;
    int         stall_slot;
    int         stall_len;
  } vec_t;
  vec_t v[6];

  sequenciador_indices #(.GEN_LAT(GEN_LAT), .MAX_TENTATIVAS(MAXT)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .perm(perm), .perm_ready(perm_ready),
    .prox_aleatorio(prox_aleatorio), .indice(indice), .indice_valido(indice_valido),
    .indice_ack(indice_ack), .pronto(pronto), .ocupado(ocupado), .erro_timeout(erro_timeout),
    .tentativas(tentativas)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_idle();
    int c;
    iniciar = 1'b0;
    for (c = 0; c < 50 && ocupado; c++) @(negedge clock);
    chk("idle_wait", int'(ocupado), 0);
  endtask

  task automatic run(input vec_t r);
    int draws = 0, n = 0, lat = -1, stall = 0, low_busy = 0;
    bit done = 0;
    logic [7:0] seq = '0;
    wait_idle();
    iniciar = 1'b1;
    indice_ack = 1'b1;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clock);
      iniciar = 1'b0;
      if (!ocupado) low_busy++;
      if (prox_aleatorio) draws++;
      perm = draws <= 1 ? r.perm1 : r.permv;
      perm_ready = r.acc != 0 && draws >= r.acc;
      if (indice_valido) begin
        if (lat < 0) lat = c + 1;
        indice_ack = !(n == r.stall_slot && stall < r.stall_len);
        if (!indice_ack) begin
          stall++;
          chk("stall_indice", int'(indice), int'((r.exp_seq >> (6 - 2 * n)) & 8'h3));
        end else begin
          seq = {seq[5:0], indice};
          n++;
        end
      end
      if (pronto) begin
        done = 1;
        chk("valido_in_fim", int'(indice_valido), 0);
      end
    end
    indice_ack = 1'b1;
    chk("pronto_seen", int'(done), 1);
    chk("seq", int'(seq), int'(r.exp_seq));
    chk("xfers", n, 4);
    chk("prox_pulses", draws, r.exp_prox);
    chk("tentativas", int'(tentativas), r.exp_prox);
    chk("erro_timeout", int'(erro_timeout), r.exp_err);
    chk("latency", lat, GEN_LAT + 3 + 4 * (r.exp_prox - 1));
    chk("ocupado_mid", low_busy, 0);
    chk("stall_cycles", stall, r.stall_len);
  endtask

  initial begin
    int n;
    bit hit;
    v[0] = '{1, 8'h36, 8'h36, 8'h36, 1, 0, 4, 0};
    v[1] = '{3, 8'hE4, 8'hE4, 8'hE4, 3, 0, 4, 0};
    v[2] = '{0, 8'h00, 8'h00, 8'h1B, MAXT, 1, 4, 0};
    v[3] = '{1, 8'h36, 8'h36, 8'h36, 1, 0, 1, 3};
    v[4] = '{MAXT, 8'h00, 8'h4E, 8'h4E, MAXT, 0, 4, 0};
`ifdef SEQ_CHECK_EN
    v[5] = '{1, 8'h00, 8'h1B, 8'h1B, 2, 0, 4, 0};
`else
    v[5] = '{1, 8'h00, 8'h1B, 8'h00, 1, 0, 4, 0};
`endif
    reset = 1'b0; iniciar = 1'b0; perm = '0; perm_ready = 1'b0; indice_ack = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_ocupado", int'(ocupado), 0);
    chk("rst_prox", int'(prox_aleatorio), 0);
    chk("rst_valido", int'(indice_valido), 0);
    chk("rst_indice", int'(indice), 0);
    chk("rst_pronto", int'(pronto), 0);
    chk("rst_erro", int'(erro_timeout), 0);
    chk("rst_tent", int'(tentativas), 0);
    reset = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 6; i++) run(v[i]);
    iniciar = 1'b1;
    perm = 8'h36; perm_ready = 1'b1; indice_ack = 1'b1;
    @(negedge clock);
    chk("fim_iniciar_ignored", int'(ocupado), 0);
    chk("fim_no_prox", int'(prox_aleatorio), 0);
    @(negedge clock);
    chk("idle_iniciar_prox", int'(prox_aleatorio), 1);
    iniciar = 1'b0;
    hit = 0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clock);
      hit = pronto;
    end
    chk("fim_seq_done", int'(hit), 1);
    chk("fim_seq_tent", int'(tentativas), 1);
    wait_idle();
    iniciar = 1'b1; perm = 8'h36; perm_ready = 1'b1; indice_ack = 1'b1;
    n = 0; hit = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      iniciar = 1'b0;
      if (indice_valido) begin
        if (n == 2) begin
          indice_ack = 1'b0;
          hit = 1;
          break;
        end
        n++;
      end
    end
    chk("reach_slot2", int'(hit), 1);
    chk("slot2_indice", int'(indice), 1);
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_ocupado", int'(ocupado), 0);
    chk("midrst_valido", int'(indice_valido), 0);
    chk("midrst_indice", int'(indice), 0);
    chk("midrst_pronto", int'(pronto), 0);
    chk("midrst_prox", int'(prox_aleatorio), 0);
    chk("midrst_tent", int'(tentativas), 0);
    chk("midrst_erro", int'(erro_timeout), 0);
    reset = 1'b1;
    indice_ack = 1'b1;
    @(negedge clock);
    chk("midrst_stays_idle", int'(ocupado), 0);
    run(v[0]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
